// File: rtl/intan_pkg.sv
// Shared widths, FSM state and FIFO entry type for the Intan MISO capture block.
// Defining MISO_DDR_EN adds the falling-edge word (word_b) to the FIFO entry.
package intan_pkg;
    localparam int CHANNEL_W = 6;
    localparam int WORD_W    = 16;
    localparam int TS_W      = 32;

    localparam logic [4:0] BIT_CNT_MAX   = 5'd17;
    localparam logic [4:0] BIT_CNT_FRAME = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH
    } cap_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]    word;
`ifdef MISO_DDR_EN
        logic [WORD_W-1:0]    word_b;
`endif
        logic [CHANNEL_W-1:0] channel;
        logic [TS_W-1:0]      timestamp;
    } fifo_entry_t;

    // Saturating so that any overlong frame can never alias to a valid count.
    function automatic logic [4:0] bit_cnt_inc(input logic [4:0] cnt);
        return (cnt == BIT_CNT_MAX) ? cnt : cnt + 5'd1;
    endfunction
endpackage

// File: rtl/capture_fifo.sv
// Power-of-two FIFO with first-word-fall-through head; pointers carry one extra
// wrap bit to separate full from empty. A push into a full FIFO is dropped unless a pop coincides.
module capture_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_valid,
    output logic o_drop
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T            r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_drop  = i_push && !w_push;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '{default: '0};
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/intan_miso_capture.sv
// Captures one 16-bit MISO word per CS frame, tags it with channel/timestamp and queues it.
// Defining MISO_DDR_EN also captures a falling-edge word, exposed on out_data_b.
module intan_miso_capture
    import intan_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MISO_DELAY = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CS,
    input  logic                 SCLK,
    input  logic                 MISO,
    input  logic [CHANNEL_W-1:0] channel,
    input  logic [TS_W-1:0]      timestamp,
    output logic [WORD_W-1:0]    out_data,
`ifdef MISO_DDR_EN
    output logic [WORD_W-1:0]    out_data_b,
`endif
    output logic [CHANNEL_W-1:0] out_channel,
    output logic [TS_W-1:0]      out_timestamp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 frame_error
);
    localparam int unsigned PW = MISO_DELAY + 1;
    typedef logic [PW-1:0] pend_t;

    cap_state_t           r_state;
    cap_state_t           w_next;
    logic                 r_cs_d;
    logic                 r_sclk_d;
    logic                 r_cs_done;
    logic                 r_fall_held;
    pend_t                r_pend_r;
    logic [WORD_W-1:0]    r_word;
    logic [4:0]           r_cnt;
    logic [CHANNEL_W-1:0] r_chan;
    logic [TS_W-1:0]      r_ts;
    logic                 r_overflow;
    logic                 r_frame_error;
    logic                 w_cs_fall;
    logic                 w_cs_rise;
    logic                 w_sclk_rise;
    logic                 w_smp_r;
    logic                 w_drain_busy;
    logic                 w_frame_ok;
    logic                 w_start;
    logic                 w_shift_en;
    logic                 w_push;
    logic                 w_bad;
    logic                 w_drop;
    fifo_entry_t          w_wr_entry;
    fifo_entry_t          w_head;

    assign w_cs_fall   = !CS && r_cs_d;
    assign w_cs_rise   = CS && !r_cs_d;
    assign w_sclk_rise = SCLK && !r_sclk_d;
    assign w_smp_r     = r_pend_r[MISO_DELAY];

`ifdef MISO_DDR_EN
    pend_t             r_pend_f;
    logic [WORD_W-1:0] r_word_b;
    logic [4:0]        r_cnt_b;
    logic              w_sclk_fall;
    logic              w_smp_f;

    assign w_sclk_fall  = !SCLK && r_sclk_d;
    assign w_smp_f      = r_pend_f[MISO_DELAY];
    assign w_drain_busy = (|r_pend_r) || (|r_pend_f);
    assign w_frame_ok   = (r_cnt == BIT_CNT_FRAME) && (r_cnt_b == BIT_CNT_FRAME);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_f <= '0;
            r_word_b <= '0;
            r_cnt_b  <= '0;
        end else begin
            r_pend_f <= (r_pend_f << 1) | pend_t'(w_shift_en && w_sclk_fall);
            if (w_start) begin
                r_word_b <= '0;
                r_cnt_b  <= '0;
            end else if (w_smp_f) begin
                r_word_b <= {r_word_b[WORD_W-2:0], MISO};
                r_cnt_b  <= bit_cnt_inc(r_cnt_b);
            end
        end
    end
`else
    assign w_drain_busy = |r_pend_r;
    assign w_frame_ok   = (r_cnt == BIT_CNT_FRAME);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FLUSH waits for the sample delay line to drain so late bits still count.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall || r_fall_held) w_next = SHIFT;
            SHIFT:   if ((w_cs_rise || r_cs_done) && !w_drain_busy) w_next = FLUSH;
            FLUSH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_push     = 1'b0;
        w_bad      = 1'b0;
        case (r_state)
            IDLE:  w_start = w_cs_fall || r_fall_held;
            SHIFT: w_shift_en = !CS && !r_cs_done;
            FLUSH: begin
                w_push = w_frame_ok;
                w_bad  = !w_frame_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs_d        <= 1'b0;
            r_sclk_d      <= 1'b0;
            r_cs_done     <= 1'b0;
            r_fall_held   <= 1'b0;
            r_pend_r      <= '0;
            r_word        <= '0;
            r_cnt         <= '0;
            r_chan        <= '0;
            r_ts          <= '0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_cs_d   <= CS;
            r_sclk_d <= SCLK;
            r_pend_r <= (r_pend_r << 1) | pend_t'(w_shift_en && w_sclk_rise);
            if (w_start) begin
                r_chan      <= channel;
                r_ts        <= timestamp;
                r_word      <= '0;
                r_cnt       <= '0;
                r_cs_done   <= 1'b0;
                r_fall_held <= 1'b0;
            end else begin
                // A new frame starting before IDLE is reached is replayed from IDLE.
                if (r_state != IDLE && w_cs_fall) r_fall_held <= 1'b1;
                if (r_state == SHIFT && w_cs_rise) r_cs_done <= 1'b1;
                if (w_smp_r) begin
                    r_word <= {r_word[WORD_W-2:0], MISO};
                    r_cnt  <= bit_cnt_inc(r_cnt);
                end
            end
            if (r_state == FLUSH) r_cs_done <= 1'b0;
            if (w_bad) r_frame_error <= 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_wr_entry           = '0;
        w_wr_entry.word      = r_word;
`ifdef MISO_DDR_EN
        w_wr_entry.word_b    = r_word_b;
`endif
        w_wr_entry.channel   = r_chan;
        w_wr_entry.timestamp = r_ts;
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fifo_entry_t)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_valid (out_valid),
        .o_drop  (w_drop)
    );

    assign out_data      = w_head.word;
`ifdef MISO_DDR_EN
    assign out_data_b    = w_head.word_b;
`endif
    assign out_channel   = w_head.channel;
    assign out_timestamp = w_head.timestamp;
    assign overflow      = r_overflow;
    assign frame_error   = r_frame_error;
endmodule

// File: tb/tb_intan_miso_capture.sv
// Bench for intan_miso_capture: two instances (MISO_DELAY 0 and 3) see the same frames,
// with MISO on the delayed instance lagging SCLK by 3 cycles; both are checked against one queue model.
module tb_intan_miso_capture;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  ch;
        logic [31:0] ts;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        CS = 1'b1;
    logic        SCLK = 1'b0;
    logic        miso0 = 1'b0;
    logic        miso3 = 1'b0;
    logic [5:0]  channel = '0;
    logic [31:0] timestamp = '0;
    logic        rdy0 = 1'b0;
    logic        rdy3 = 1'b0;

    logic [15:0] d0, d3;
    logic [5:0]  c0, c3;
    logic [31:0] t0, t3;
    logic        v0, v3, ov0, ov3, fe0, fe3;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];
    logic exp_ovf = 1'b0;
    logic exp_ferr = 1'b0;

    always #5 clk = ~clk;

    intan_miso_capture #(.FIFO_DEPTH(DEPTH), .MISO_DELAY(0)) dut0 (
        .clk(clk), .reset(reset), .CS(CS), .SCLK(SCLK), .MISO(miso0),
        .channel(channel), .timestamp(timestamp),
        .out_data(d0), .out_channel(c0), .out_timestamp(t0),
        .out_valid(v0), .out_ready(rdy0), .overflow(ov0), .frame_error(fe0)
    );

    intan_miso_capture #(.FIFO_DEPTH(DEPTH), .MISO_DELAY(3)) dut3 (
        .clk(clk), .reset(reset), .CS(CS), .SCLK(SCLK), .MISO(miso3),
        .channel(channel), .timestamp(timestamp),
        .out_data(d3), .out_channel(c3), .out_timestamp(t3),
        .out_valid(v3), .out_ready(rdy3), .overflow(ov3), .frame_error(fe3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic bitof(input logic [15:0] w, input int j);
        logic [15:0] t;
        t = w >> (15 - (j % 16));
        return t[0];
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: 16-bit frames enqueue {word,channel,timestamp}; others flag frame_error.
    task automatic model_frame(input logic [15:0] w, input int nb, input logic [5:0] ch,
                               input logic [31:0] ts, input bit pulse);
        exp_t e;
        e.d = w;
        e.ch = ch;
        e.ts = ts;
        if (nb != 16) exp_ferr = 1'b1;
        else begin
            if (pulse && q.size() > 0) void'(q.pop_front());
            if (q.size() < DEPTH) q.push_back(e);
            else exp_ovf = 1'b1;
        end
    endtask

    // SCLK: 2 cycles high / 2 low per bit; CS rises mid low phase of the last bit.
    task automatic send_frame(input logic [15:0] w, input int nb, input logic [5:0] ch,
                              input logic [31:0] ts, input bit chained, input bit early_next,
                              input logic [5:0] nch, input logic [31:0] nts, input bit pulse);
        if (!chained) begin
            @(negedge clk);
            CS = 1'b0;
            channel = ch;
            timestamp = ts;
        end
        for (int c = 0; c < nb * 4 + 6; c++) begin
            @(negedge clk);
            SCLK  = (c < nb * 4) && (c % 4 < 2);
            miso0 = (c < nb * 4) ? bitof(w, c / 4) : 1'b0;
            miso3 = (c >= 3 && c - 3 < nb * 4) ? bitof(w, (c - 3) / 4) : 1'b0;
            if (c == nb * 4 - 2) CS = 1'b1;
            if (early_next && c == nb * 4 - 1) begin
                CS = 1'b0;
                channel = nch;
                timestamp = nts;
            end
            // Ready strobed only on each instance's push cycle
            rdy0 = pulse && (c == nb * 4 - 1);
            rdy3 = pulse && (c == nb * 4 + 2);
        end
        SCLK = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".valid0"}, v0, q.size() != 0);
        check({tag, ".valid3"}, v3, q.size() != 0);
        if (q.size() != 0) begin
            check({tag, ".data0"}, d0, q[0].d);
            check({tag, ".data3"}, d3, q[0].d);
            check({tag, ".chan0"}, c0, q[0].ch);
            check({tag, ".chan3"}, c3, q[0].ch);
            check({tag, ".ts0"}, t0, q[0].ts);
            check({tag, ".ts3"}, t3, q[0].ts);
        end
        check({tag, ".ovf0"}, ov0, exp_ovf);
        check({tag, ".ovf3"}, ov3, exp_ovf);
        check({tag, ".ferr0"}, fe0, exp_ferr);
        check({tag, ".ferr3"}, fe3, exp_ferr);
    endtask

    task automatic drain(input string tag);
        exp_t snap[$];
        int   i0;
        int   i3;
        snap = q;
        i0 = 0;
        i3 = 0;
        for (int k = 0; k < 3 * DEPTH + 4; k++) begin
            @(negedge clk);
            if (v0) begin
                if (i0 < snap.size()) begin
                    check({tag, ".pop_data0"}, d0, snap[i0].d);
                    check({tag, ".pop_chan0"}, c0, snap[i0].ch);
                    check({tag, ".pop_ts0"}, t0, snap[i0].ts);
                end
                i0++;
            end
            if (v3) begin
                if (i3 < snap.size()) begin
                    check({tag, ".pop_data3"}, d3, snap[i3].d);
                    check({tag, ".pop_chan3"}, c3, snap[i3].ch);
                    check({tag, ".pop_ts3"}, t3, snap[i3].ts);
                end
                i3++;
            end
            rdy0 = 1'b1;
            rdy3 = 1'b1;
        end
        rdy0 = 1'b0;
        rdy3 = 1'b0;
        check({tag, ".pop_count0"}, i0, snap.size());
        check({tag, ".pop_count3"}, i3, snap.size());
        q.delete();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        @(negedge clk);
        check_status(tag);
        check({tag, ".rst_data0"}, d0, 0);
        check({tag, ".rst_data3"}, d3, 0);
        check({tag, ".rst_chan0"}, c0, 0);
        check({tag, ".rst_chan3"}, c3, 0);
        check({tag, ".rst_ts0"}, t0, 0);
        check({tag, ".rst_ts3"}, t3, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic frame(input string tag, input logic [15:0] w, input int nb,
                         input logic [5:0] ch, input logic [31:0] ts);
        send_frame(w, nb, ch, ts, 1'b0, 1'b0, '0, '0, 1'b0);
        model_frame(w, nb, ch, ts, 1'b0);
        idle(2);
        check_status(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w, w2;
        logic [5:0]  ch, ch2;
        logic [31:0] ts, ts2;

        do_reset("reset_init");
        idle(3);
        check_status("post_reset");

        frame("single", 16'hA5C3, 16, 6'd5, 32'd7);
        drain("single");

        for (int f = 0; f < 8; f++) begin
            w = 16'($urandom);
            ch = 6'($urandom_range(0, 63));
            ts = $urandom;
            frame("rand", w, 16, ch, ts);
            if (q.size() >= 3 || $urandom_range(0, 1) == 1) drain("rand");
        end
        drain("rand_end");

        for (int f = 0; f < 5; f++) begin
            frame("backpressure", 16'(f), 16, 6'($urandom_range(0, 63)), $urandom);
        end
        drain("bp_drain");
        do_reset("reset_ovf");

        for (int f = 0; f < 4; f++) begin
            frame("fill", 16'($urandom), 16, 6'(f), $urandom);
        end
        w = 16'($urandom);
        ts = $urandom;
        send_frame(w, 16, 6'd9, ts, 1'b0, 1'b0, '0, '0, 1'b1);
        model_frame(w, 16, 6'd9, ts, 1'b1);
        idle(2);
        check_status("full_push_pop");
        drain("full_drain");

        w = 16'($urandom);
        w2 = 16'($urandom);
        ch = 6'($urandom_range(0, 63));
        ch2 = 6'($urandom_range(0, 63));
        ts = $urandom;
        ts2 = $urandom;
        send_frame(w, 16, ch, ts, 1'b0, 1'b1, ch2, ts2, 1'b0);
        model_frame(w, 16, ch, ts, 1'b0);
        send_frame(w2, 16, ch2, ts2, 1'b1, 1'b0, '0, '0, 1'b0);
        model_frame(w2, 16, ch2, ts2, 1'b0);
        idle(2);
        check_status("back_to_back");
        drain("b2b_drain");

        frame("ones", 16'hFFFF, 16, 6'd1, 32'd100);
        frame("one", 16'h0001, 16, 6'd2, 32'd200);
        drain("delay_drain");

        frame("short", 16'($urandom), 15, 6'd3, 32'd300);
        frame("after_short", 16'h1234, 16, 6'd4, 32'd400);
        drain("short_drain");

        do_reset("reset_err");
        frame("long48", 16'($urandom), 48, 6'd6, 32'd600);
        do_reset("reset_err2");
        frame("long17", 16'($urandom), 17, 6'd7, 32'd700);
        do_reset("reset_err3");

        @(negedge clk);
        CS = 1'b0;
        channel = 6'd11;
        timestamp = 32'd1100;
        w = 16'($urandom);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            SCLK = (c % 4 < 2);
            miso0 = bitof(w, c / 4);
            miso3 = (c >= 3) ? bitof(w, (c - 3) / 4) : 1'b0;
        end
        SCLK = 1'b0;
        do_reset("reset_mid");
        idle(6);
        check_status("cs_low_release");
        @(negedge clk);
        CS = 1'b1;
        idle(6);
        check_status("cs_rise_after_release");
        frame("beef", 16'hBEEF, 16, 6'd12, 32'd1200);
        drain("beef_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/intan_miso_capture.md
INTAN_MISO_CAPTURE -- requirements
Module: intan_miso_capture

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the output FIFO depth in words and SHALL be a power of two, 2..16.
REQ-002 Parameter MISO_DELAY, default 0, is the MISO sample delay in clk cycles after the SCLK rising edge, 0..7, for cable compensation.
REQ-003 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 CS  in  1  chip select from the SPI master; low marks one frame.
REQ-006 SCLK  in  1  SPI clock from the SPI master, generated synchronously to clk.
REQ-007 MISO  in  1  serial data from the Intan chip.
REQ-008 channel  in  6  channel index of the frame in flight.
REQ-009 timestamp  in  32  sample timestamp of the frame in flight.
REQ-010 out_data  out  16  captured word, MSB first on the wire.
REQ-011 out_channel  out  6  channel latched at the CS falling edge.
REQ-012 out_timestamp  out  32  timestamp latched at the CS falling edge.
REQ-013 out_valid / out_ready  out / in  1 each  valid/ready handshake on the FIFO head.
REQ-014 overflow, frame_error  out  1 each  sticky error flags.

Function
REQ-015 The block SHALL detect SCLK and CS edges by comparing each against a registered copy of itself; no other clock domain exists.
REQ-016 FSM states: IDLE, SHIFT, FLUSH.
- IDLE→SHIFT on a CS falling edge: latch channel and timestamp, clear the bit counter.
- SHIFT→FLUSH on a CS rising edge.
- FLUSH→IDLE after one cycle.
REQ-017 In SHIFT, MISO SHALL be sampled MISO_DELAY+1 clk cycles after each SCLK rising edge and shifted in MSB first; the 5-bit bit counter saturates at 17.
REQ-018 On reaching FLUSH with a bit count of exactly 16, the FSM SHALL push {word, channel, timestamp} into the FIFO.
- Any other bit count: discard the word and set frame_error.
REQ-019 A sample pending in the delay line when CS rises SHALL still be counted before the FLUSH decision.
- FLUSH is deferred until the delay line is empty.
REQ-020 The FIFO head SHALL drive the out_* signals; out_valid = not empty.
- A pop occurs on a cycle where out_valid and out_ready are both high.
- out_data, out_channel and out_timestamp SHALL hold stable while out_valid is high and out_ready is low.
REQ-021 A push to a full FIFO with no simultaneous pop SHALL be dropped and SHALL set overflow.
- A push and pop in the same cycle when full SHALL both succeed.
REQ-022 Push-to-out_valid latency SHALL be 1 clk cycle when the FIFO is empty.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to tell full from empty.
REQ-024 A CS falling edge during FLUSH SHALL be honoured in the following IDLE cycle, so no frame is lost.

Reset
REQ-025 While reset is low: FSM=IDLE, counters=0, FIFO empty, out_valid=0, out_data=0, out_channel=0, out_timestamp=0, overflow=0, frame_error=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial word.
- After release, the block SHALL wait in IDLE for the next CS falling edge; a CS already low at release SHALL NOT start a frame.
REQ-027 The only way to clear overflow and frame_error SHALL be reset.

Configuration
REQ-028 With MISO_DDR_EN defined, the block SHALL also sample MISO on SCLK falling edges (same delay) into a second word.
- Adds output out_data_b[15:0], carried through the FIFO alongside out_data.
- Frame validity requires 16 bits on both edges.
REQ-029 Without MISO_DDR_EN, out_data_b and its FIFO storage SHALL NOT exist.

Structure
REQ-030 Package intan_pkg SHALL hold CHANNEL_W=6, WORD_W=16, TS_W=32, the FSM state enum, and the FIFO entry struct.
REQ-031 The FIFO SHALL be a separate sub-module, capture_fifo, parameterised by depth and entry type.

Verification
REQ-032 Single frame, MISO_DELAY=0: 16 SCLK pulses shift 0xA5C3, channel=5, timestamp=7 → one out_valid with out_data=0xA5C3, out_channel=5, out_timestamp=7.
REQ-033 Short frame: CS rises after 15 SCLKs → no push, frame_error=1; the next good 0x1234 frame is still delivered.
REQ-034 Backpressure: out_ready=0, 5 frames with FIFO_DEPTH=4 → 4 words held unchanged, overflow=1; releasing out_ready pops the words in order 0,1,2,3.
REQ-035 Full with simultaneous push/pop: FIFO full, out_ready=1 on the push cycle → no overflow, count stays 4.
REQ-036 MISO_DELAY=3 with MISO lagging SCLK by 3 cycles, data 0xFFFF then 0x0001 → both words captured exactly.
REQ-037 Reset after 8 bits of a frame → out_valid=0; the next full 0xBEEF frame is captured correctly.
